// File: rtl/onchip_ram_pkg.sv
// Shared constants for the Avalon on-chip RAM: response codes and the
// supported read-pipeline depths.
package onchip_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 2;

    // Any request beyond the deepest supported pipeline collapses onto it.
    function automatic int rl_stages(input int rl);
        return (rl >= RL_MAX) ? RL_MAX : RL_MIN;
    endfunction

endpackage

// File: rtl/onchip_ram_array.sv
// Byte-lane single-port storage with a registered read port. One inferred
// memory per lane so each lane gets its own write enable.
module onchip_ram_array #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 51200,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rd_en,
    input  logic [LANES-1:0]        we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [LANES*LANE_W-1:0] wdata,
    output logic [LANES*LANE_W-1:0] rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] mem_reg [DEPTH];
            logic [LANE_W-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem_reg[addr] <= wdata[gi*LANE_W +: LANE_W];
                end
                if (rd_en) begin
                    rdata_reg <= mem_reg[addr];
                end
            end

            assign rdata[gi*LANE_W +: LANE_W] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/avalon_onchip_ram.sv
// Avalon-MM on-chip RAM slave: address decode, 1- or 2-stage read pipeline,
// error responses. Define ONCHIP_RAM_PARITY_EN for per-byte even parity.
module avalon_onchip_ram
    import onchip_ram_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 51200,
    parameter int    ADDR_W       = 16,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_ram.hex"
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic [1:0]          response,
    output logic                parity_err
);

    localparam int LANES = DATA_W / 8;
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
`ifdef ONCHIP_RAM_PARITY_EN
        logic              perr;
`endif
    } result_t;

    logic                    in_range;
    logic                    accept_rd;
    logic                    accept_wr;
    logic [LANES-1:0]        arr_we;
    logic [LANES*LANE_W-1:0] arr_wdata;
    logic [LANES*LANE_W-1:0] arr_rdata;
    logic [DATA_W-1:0]       raw_data;
`ifdef ONCHIP_RAM_PARITY_EN
    logic [LANES-1:0]        lane_perr;
`endif
    logic                    s1_valid_reg;
    logic                    s1_oob_reg;
    result_t                 s1_result;
    logic                    out_valid;
    result_t                 out_result;

    assign in_range  = 32'(address) < 32'(DEPTH);
    assign accept_wr = chipselect & write & clken;
    assign accept_rd = chipselect & read & ~write & clken;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign arr_we[gi] = accept_wr & in_range & byteenable[gi];
`ifdef ONCHIP_RAM_PARITY_EN
            assign arr_wdata[gi*LANE_W +: LANE_W] = {^writedata[gi*8 +: 8], writedata[gi*8 +: 8]};
            assign lane_perr[gi] = ^arr_rdata[gi*LANE_W +: LANE_W];
`else
            assign arr_wdata[gi*LANE_W +: LANE_W] = writedata[gi*8 +: 8];
`endif
            assign raw_data[gi*8 +: 8] = arr_rdata[gi*LANE_W +: 8];
        end
    endgenerate

    onchip_ram_array #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rd_en (accept_rd & in_range),
        .we    (arr_we),
        .addr  (address),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Stage 1 tracks the read issued alongside the array's registered read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg <= 1'b0;
            s1_oob_reg   <= 1'b0;
        end else if (clken) begin
            s1_valid_reg <= accept_rd;
            s1_oob_reg   <= ~in_range;
        end
    end

    always_comb begin
        s1_result = '0;
        if (s1_oob_reg) begin
            s1_result.resp = RESP_SLVERR;
        end else begin
            s1_result.data = raw_data;
            s1_result.resp = RESP_OKAY;
`ifdef ONCHIP_RAM_PARITY_EN
            s1_result.perr = |lane_perr;
            if (|lane_perr) begin
                s1_result.resp = RESP_SLVERR;
            end
`endif
        end
    end

    generate
        if (rl_stages(READ_LATENCY) == RL_MAX) begin : g_lat2
            logic    s2_valid_reg;
            result_t s2_result_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s2_valid_reg  <= 1'b0;
                    s2_result_reg <= '0;
                end else if (clken) begin
                    s2_valid_reg  <= s1_valid_reg;
                    s2_result_reg <= s1_result;
                end
            end

            assign out_valid  = s2_valid_reg;
            assign out_result = s2_result_reg;
        end else begin : g_lat1
            assign out_valid  = s1_valid_reg;
            assign out_result = s1_result;
        end
    endgenerate

    // A frozen pipeline holds its result but must not present it.
    assign waitrequest   = ~clken;
    assign readdatavalid = out_valid & clken;
    assign readdata      = readdatavalid ? out_result.data : '0;
    assign response      = readdatavalid ? out_result.resp : RESP_OKAY;
`ifdef ONCHIP_RAM_PARITY_EN
    assign parity_err    = readdatavalid & out_result.perr;
`else
    assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_onchip_ram.sv
// Directed bench for avalon_onchip_ram: two instances (READ_LATENCY 1 and 2)
// share every input; each scenario task checks both against fixed values.
module tb_avalon_onchip_ram;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 51200;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          chipselect = 1'b0;
    logic          read       = 1'b0;
    logic          write      = 1'b0;
    logic          clken      = 1'b1;
    logic [AW-1:0] address    = '0;
    logic [3:0]    byteenable = '0;
    logic [DW-1:0] writedata  = '0;

    logic          waitrequest   [2];
    logic [DW-1:0] readdata      [2];
    logic          readdatavalid [2];
    logic [1:0]    response      [2];
    logic          parity_err    [2];

    int checks = 0;
    int passed = 0;

    int            hit_cnt   [2];
    int            hit_first [2];
    int            hit_last  [2];
    int            leak      [2];
    logic [DW-1:0] hit_data  [2][4];
    logic [1:0]    hit_resp  [2];
    logic          hit_perr  [2];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            avalon_onchip_ram #(
                .DATA_W       (DW),
                .DEPTH        (DEPTH),
                .ADDR_W       (AW),
                .READ_LATENCY (gi + 1),
                .INIT_FILE    ("")
            ) dut (
                .clk           (clk),
                .reset_n       (reset_n),
                .chipselect    (chipselect),
                .address       (address),
                .read          (read),
                .write         (write),
                .byteenable    (byteenable),
                .writedata     (writedata),
                .clken         (clken),
                .waitrequest   (waitrequest[gi]),
                .readdata      (readdata[gi]),
                .readdatavalid (readdatavalid[gi]),
                .response      (response[gi]),
                .parity_err    (parity_err[gi])
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
        tick();
        chipselect = 1'b0; write = 1'b0; byteenable = '0;
    endtask

    task automatic issue_read(input logic [AW-1:0] a);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
    endtask

    // Records readdatavalid pulses over ncyc cycles; cycle 1 follows the last accepting edge.
    task automatic observe(input int ncyc);
        for (int i = 0; i < 2; i++) begin
            hit_cnt[i] = 0; hit_first[i] = 0; hit_last[i] = 0; leak[i] = 0;
            hit_resp[i] = 2'b00; hit_perr[i] = 1'b0;
        end
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (readdatavalid[i] === 1'b1) begin
                    if (hit_cnt[i] < 4) hit_data[i][hit_cnt[i]] = readdata[i];
                    if (hit_cnt[i] == 0) begin
                        hit_first[i] = k; hit_resp[i] = response[i]; hit_perr[i] = parity_err[i];
                    end
                    hit_last[i] = k;
                    hit_cnt[i]++;
                end else if (readdata[i] !== '0) begin
                    leak[i]++;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (readdatavalid[i] !== 1'b0) $display("FAIL reset_rdv RL%0d: got %b want 0", i+1, readdatavalid[i]); else passed++;
            checks++;
            if (readdata[i] !== '0) $display("FAIL reset_data RL%0d: got %h want 0", i+1, readdata[i]); else passed++;
            checks++;
            if (response[i] !== 2'b00) $display("FAIL reset_resp RL%0d: got %b want 00", i+1, response[i]); else passed++;
            checks++;
            if (parity_err[i] !== 1'b0) $display("FAIL reset_perr RL%0d: got %b want 0", i+1, parity_err[i]); else passed++;
            checks++;
            if (waitrequest[i] !== 1'b0) $display("FAIL reset_wait RL%0d: got %b want 0", i+1, waitrequest[i]); else passed++;
        end
        tick();
        reset_n = 1'b1;
        tick();
        $display("test_reset done: %0d/%0d", passed, checks);
    endtask

    task automatic test_write_read();
        do_write(16'd5, 32'hDEADBEEF, 4'hF);
        issue_read(16'd5);
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_cnt[i] !== 1) $display("FAIL wr_rd_count RL%0d: got %0d want 1", i+1, hit_cnt[i]); else passed++;
            checks++;
            if (hit_first[i] !== i + 1) $display("FAIL wr_rd_latency RL%0d: got %0d want %0d", i+1, hit_first[i], i+1); else passed++;
            checks++;
            if (hit_data[i][0] !== 32'hDEADBEEF) $display("FAIL wr_rd_data RL%0d: got %h want deadbeef", i+1, hit_data[i][0]); else passed++;
            checks++;
            if (hit_resp[i] !== 2'b00) $display("FAIL wr_rd_resp RL%0d: got %b want 00", i+1, hit_resp[i]); else passed++;
            checks++;
            if (leak[i] !== 0) $display("FAIL wr_rd_idle_zero RL%0d: got %0d nonzero cycles want 0", i+1, leak[i]); else passed++;
        end
        $display("test_write_read done: %0d/%0d", passed, checks);
    endtask

    task automatic test_byteenable();
        do_write(16'd7, 32'h11223344, 4'hF);
        do_write(16'd7, 32'hAABBCCDD, 4'b0101);
        do_write(16'd7, 32'hFFFFFFFF, 4'b0000);
        issue_read(16'd7);
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_cnt[i] !== 1) $display("FAIL be_count RL%0d: got %0d want 1", i+1, hit_cnt[i]); else passed++;
            checks++;
            if (hit_data[i][0] !== 32'h11BB33DD) $display("FAIL be_data RL%0d: got %h want 11bb33dd", i+1, hit_data[i][0]); else passed++;
        end
        $display("test_byteenable done: %0d/%0d", passed, checks);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 4; a++) do_write(AW'(a), 32'hC0DE0000 + DW'(a), 4'hF);
        fork
            begin
                for (int a = 0; a < 4; a++) begin
                    chipselect = 1'b1; read = 1'b1; address = AW'(a);
                    tick();
                end
                chipselect = 1'b0; read = 1'b0;
            end
            observe(7);
        join
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_cnt[i] !== 4) $display("FAIL b2b_count RL%0d: got %0d want 4", i+1, hit_cnt[i]); else passed++;
            checks++;
            if (hit_first[i] !== i + 2) $display("FAIL b2b_first RL%0d: got %0d want %0d", i+1, hit_first[i], i+2); else passed++;
            checks++;
            if (hit_last[i] !== i + 5) $display("FAIL b2b_last RL%0d: got %0d want %0d", i+1, hit_last[i], i+5); else passed++;
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (hit_data[i][j] !== 32'hC0DE0000 + DW'(j))
                    $display("FAIL b2b_order RL%0d beat %0d: got %h want %h", i+1, j, hit_data[i][j], 32'hC0DE0000 + DW'(j));
                else passed++;
            end
        end
        $display("test_back_to_back done: %0d/%0d", passed, checks);
    endtask

    task automatic test_write_first();
        chipselect = 1'b1; write = 1'b1; address = 16'd9; writedata = 32'h5A5A1234; byteenable = 4'hF;
        tick();
        write = 1'b0; read = 1'b1; byteenable = '0;
        tick();
        chipselect = 1'b0; read = 1'b0;
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_first[i] !== i + 1) $display("FAIL wf_latency RL%0d: got %0d want %0d", i+1, hit_first[i], i+1); else passed++;
            checks++;
            if (hit_data[i][0] !== 32'h5A5A1234) $display("FAIL wf_data RL%0d: got %h want 5a5a1234", i+1, hit_data[i][0]); else passed++;
        end
        $display("test_write_first done: %0d/%0d", passed, checks);
    endtask

    task automatic test_rw_collision();
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 16'd10; writedata = 32'h0BADCAFE; byteenable = 4'hF;
        tick();
        chipselect = 1'b0; read = 1'b0; write = 1'b0; byteenable = '0;
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_cnt[i] !== 0) $display("FAIL rw_no_rdv RL%0d: got %0d pulses want 0", i+1, hit_cnt[i]); else passed++;
        end
        issue_read(16'd10);
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_data[i][0] !== 32'h0BADCAFE) $display("FAIL rw_written RL%0d: got %h want 0badcafe", i+1, hit_data[i][0]); else passed++;
        end
        $display("test_rw_collision done: %0d/%0d", passed, checks);
    endtask

    task automatic test_out_of_range();
        issue_read(AW'(DEPTH));
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_first[i] !== i + 1) $display("FAIL oob_latency RL%0d: got %0d want %0d", i+1, hit_first[i], i+1); else passed++;
            checks++;
            if (hit_data[i][0] !== '0) $display("FAIL oob_data RL%0d: got %h want 0", i+1, hit_data[i][0]); else passed++;
            checks++;
            if (hit_resp[i] !== 2'b10) $display("FAIL oob_resp RL%0d: got %b want 10", i+1, hit_resp[i]); else passed++;
        end
        do_write(AW'(DEPTH), 32'hCAFEF00D, 4'hF);
        issue_read(16'd0);
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_data[i][0] !== 32'hC0DE0000) $display("FAIL oob_wr_dropped RL%0d: got %h want c0de0000", i+1, hit_data[i][0]); else passed++;
            checks++;
            if (hit_resp[i] !== 2'b00) $display("FAIL oob_wr_resp RL%0d: got %b want 00", i+1, hit_resp[i]); else passed++;
        end
        do_write(AW'(DEPTH - 1), 32'h600DF00D, 4'hF);
        issue_read(AW'(DEPTH - 1));
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_data[i][0] !== 32'h600DF00D) $display("FAIL last_word_data RL%0d: got %h want 600df00d", i+1, hit_data[i][0]); else passed++;
            checks++;
            if (hit_resp[i] !== 2'b00) $display("FAIL last_word_resp RL%0d: got %b want 00", i+1, hit_resp[i]); else passed++;
        end
        $display("test_out_of_range done: %0d/%0d", passed, checks);
    endtask

    task automatic test_clken();
        issue_read(16'd5);
        clken = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (waitrequest[i] !== 1'b1) $display("FAIL frz_wait RL%0d cyc %0d: got %b want 1", i+1, c, waitrequest[i]); else passed++;
                checks++;
                if (readdatavalid[i] !== 1'b0) $display("FAIL frz_rdv RL%0d cyc %0d: got %b want 0", i+1, c, readdatavalid[i]); else passed++;
            end
            tick();
        end
        clken = 1'b1;
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_cnt[i] !== 1) $display("FAIL frz_count RL%0d: got %0d want 1", i+1, hit_cnt[i]); else passed++;
            checks++;
            if (hit_first[i] !== i + 1) $display("FAIL frz_resume RL%0d: got %0d want %0d", i+1, hit_first[i], i+1); else passed++;
            checks++;
            if (hit_data[i][0] !== 32'hDEADBEEF) $display("FAIL frz_data RL%0d: got %h want deadbeef", i+1, hit_data[i][0]); else passed++;
        end
        $display("test_clken done: %0d/%0d", passed, checks);
    endtask

    task automatic test_reset_mid_read();
        issue_read(16'd5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        observe(4);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_cnt[i] !== 0) $display("FAIL rst_discard RL%0d: got %0d pulses want 0", i+1, hit_cnt[i]); else passed++;
        end
        issue_read(16'd5);
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_data[i][0] !== 32'hDEADBEEF) $display("FAIL rst_keeps_array RL%0d: got %h want deadbeef", i+1, hit_data[i][0]); else passed++;
        end
        $display("test_reset_mid_read done: %0d/%0d", passed, checks);
    endtask

    task automatic test_parity();
        logic       exp_perr;
        logic [1:0] exp_resp;
        do_write(16'd20, 32'h12345678, 4'hF);
`ifdef ONCHIP_RAM_PARITY_EN
        g_dut[0].dut.u_array.g_lane[0].mem_reg[20][8] = ~g_dut[0].dut.u_array.g_lane[0].mem_reg[20][8];
        g_dut[1].dut.u_array.g_lane[0].mem_reg[20][8] = ~g_dut[1].dut.u_array.g_lane[0].mem_reg[20][8];
        exp_perr = 1'b1;
        exp_resp = 2'b10;
`else
        exp_perr = 1'b0;
        exp_resp = 2'b00;
`endif
        issue_read(16'd20);
        observe(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hit_cnt[i] !== 1) $display("FAIL par_count RL%0d: got %0d want 1", i+1, hit_cnt[i]); else passed++;
            checks++;
            if (hit_perr[i] !== exp_perr) $display("FAIL par_err RL%0d: got %b want %b", i+1, hit_perr[i], exp_perr); else passed++;
            checks++;
            if (hit_resp[i] !== exp_resp) $display("FAIL par_resp RL%0d: got %b want %b", i+1, hit_resp[i], exp_resp); else passed++;
            checks++;
            if (hit_data[i][0] !== 32'h12345678) $display("FAIL par_data RL%0d: got %h want 12345678", i+1, hit_data[i][0]); else passed++;
        end
        $display("test_parity done: %0d/%0d", passed, checks);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_back_to_back();
        test_write_first();
        test_rw_collision();
        test_out_of_range();
        test_clken();
        test_reset_mid_read();
        test_parity();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

endmodule
